// File: rtl/aes_pkg.sv
// Shared definitions for the block serializer slice.
//   BLOCK_BYTES : bytes per block
//   block_t     : one 128-bit block, byte [0] is the first byte on the wire
//   sb_state_e  : split_block control states
package aes_pkg;
  localparam int BLOCK_BYTES = 16;

  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

  typedef enum logic {
    SB_IDLE = 1'b0,  // no active block
    SB_SEND = 1'b1   // active block being sent
  } sb_state_e;
endpackage

// File: rtl/block_hold_reg.sv
// One-entry block holding register with a full flag.
//   clk_in    : clock
//   rst_in    : synchronous active-high reset, clears data and full
//   load      : capture load_data and set full
//   unload    : clear full (data is taken by the consumer in the same cycle)
//   load_data : block to capture
//   data      : held block
//   full      : entry occupied
module block_hold_reg
  import aes_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   load,
  input  logic   unload,
  input  block_t load_data,
  output block_t data,
  output logic   full
);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= load_data;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/split_block.sv
// Serializes 128-bit blocks into a byte stream with valid/ready on both sides.
// One active block is being sent while a second may wait in a pending slot,
// so consecutive blocks stream without a bubble between byte 15 and byte 0.
//   clk_in         : clock
//   rst_in         : synchronous active-high reset
//   block_in       : block to serialize, byte [0] first
//   valid_in       : block_in valid
//   ready_out      : a block can be accepted (pending slot empty)
//   byte_out       : current byte, 0 when not valid
//   byte_valid_out : byte_out valid
//   byte_ready_in  : downstream accepts byte_out
//   last_out       : byte_out is byte [15] of its block
//   busy_out       : an active or pending block is held
module split_block
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = BLOCK_BYTES
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_BYTES-1:0][7:0] block_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [7:0]                byte_out,
  output logic                      byte_valid_out,
  input  logic                      byte_ready_in,
  output logic                      last_out,
  output logic                      busy_out
);

  localparam int                IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);

  sb_state_e        state_q, state_d;
  block_t           act_q, act_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             bvalid_q, bvalid_d;
  logic             last_q, last_d;

  block_t pend_data;
  logic   pend_full, pend_load, pend_unload;

  logic accept, xfer, last_xfer, load_from_in;

  // ready is purely the inverted pending flop, never a function of this
  // cycle's inputs.
  assign ready_out      = !pend_full;
  assign byte_out       = byte_q;
  assign byte_valid_out = bvalid_q;
  assign last_out       = last_q;
  assign busy_out       = (state_q == SB_SEND) || pend_full;

  assign accept    = valid_in && ready_out;
  assign xfer      = bvalid_q && byte_ready_in;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  block_hold_reg u_pend (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (pend_load),
    .unload    (pend_unload),
    .load_data (block_t'(block_in)),
    .data      (pend_data),
    .full      (pend_full)
  );

  // State register plus the registered datapath/outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= SB_IDLE;
      act_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      last_q   <= last_d;
    end
  end

  // Next state. SEND is held across byte 15 whenever another block is
  // ready to follow (pending, or arriving this very cycle).
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (accept) state_d = SB_SEND;
      SB_SEND: if (last_xfer && !pend_full && !accept) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  // Slot steering and next output byte. The new block bypasses the pending
  // slot when the active slot is free now or frees up at this edge.
  always_comb begin
    load_from_in = accept && ((state_q == SB_IDLE) || (last_xfer && !pend_full));
    pend_load    = accept && !load_from_in;
    pend_unload  = last_xfer && pend_full;

    act_d = act_q;
    if (load_from_in)     act_d = block_t'(block_in);
    else if (pend_unload) act_d = pend_data;

    // Index wraps 15 -> 0 on the last transfer, landing on byte [0] of
    // whichever block follows.
    idx_d = xfer ? idx_q + 1'b1 : idx_q;

    // Outputs are precomputed from next-cycle state so they are registered
    // and naturally hold during a stall (nothing above changes).
    if (state_d == SB_SEND) begin
      byte_d   = act_d[idx_d];
      bvalid_d = 1'b1;
      last_d   = (idx_d == LAST_IDX);
    end else begin
      byte_d   = 8'h00;
      bvalid_d = 1'b0;
      last_d   = 1'b0;
    end
  end

endmodule
